// File: rtl/decoder.sv
// rtl/decoder.sv - registered 4-bit binary to 2-digit BCD converter
module decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] binary,
  output logic [5:0] bcd
);

  logic       tens;
  logic [3:0] ones;
  logic [5:0] next_bcd;

  // Compare-and-subtract: a 4-bit value holds at most one ten, so one
  // comparison against 10 fully decides both digits.
  always_comb begin
    tens     = 1'b0;
    ones     = binary;
    next_bcd = 6'b00_0000;
    if (binary >= 4'd10) begin
      tens = 1'b1;
      ones = binary - 4'd10;
    end
    next_bcd = {1'b0, tens, ones};
  end

  // Output register: the display side only ever sees flop outputs, and reset wins over conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd <= 6'b00_0000;
    end else begin
      bcd <= next_bcd;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - directed self-checking bench for decoder
`timescale 1ns/1ps
module tb_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] binary;
  logic [5:0] bcd;

  int total  = 0;
  int passed = 0;

  decoder dut (
    .clk    (clk),
    .rst    (rst),
    .binary (binary),
    .bcd    (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  // Drive inputs on the falling edge, then settle just past the rising edge.
  task automatic apply(input logic [3:0] v, input logic r);
    @(negedge clk);
    binary = v;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed BCD for every input code 0..15.
  logic [5:0] table_bcd [16] = '{
    6'b00_0000, 6'b00_0001, 6'b00_0010, 6'b00_0011,
    6'b00_0100, 6'b00_0101, 6'b00_0110, 6'b00_0111,
    6'b00_1000, 6'b00_1001, 6'b01_0000, 6'b01_0001,
    6'b01_0010, 6'b01_0011, 6'b01_0100, 6'b01_0101
  };

  logic [3:0] lo_in  [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
  logic [5:0] lo_exp [4] = '{6'b00_0000, 6'b00_0001, 6'b00_0010, 6'b00_0011};
  logic [3:0] hi_in  [4] = '{4'b1111, 4'b1110, 4'b1101, 4'b1100};
  logic [5:0] hi_exp [4] = '{6'b01_0101, 6'b01_0100, 6'b01_0011, 6'b01_0010};
  logic [3:0] bd_in  [3] = '{4'b1001, 4'b1010, 4'b1011};
  logic [5:0] bd_exp [3] = '{6'b00_1001, 6'b01_0000, 6'b01_0001};

  initial begin
    rst    = 1'b1;
    binary = 4'b1111;

    // Reset held two cycles with the largest input present
    apply(4'b1111, 1'b1);
    check("reset_c1", bcd, 6'b00_0000);
    apply(4'b1111, 1'b1);
    check("reset_c2", bcd, 6'b00_0000);
    apply(4'b1111, 1'b0);
    check("post_reset", bcd, 6'b01_0101);

    for (int i = 0; i < 4; i++) begin
      apply(lo_in[i], 1'b0);
      check($sformatf("low_%0d", i), bcd, lo_exp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      apply(hi_in[i], 1'b0);
      check($sformatf("high_%0d", i), bcd, hi_exp[i]);
    end
    for (int i = 0; i < 3; i++) begin
      apply(bd_in[i], 1'b0);
      check($sformatf("bound_%0d", i), bcd, bd_exp[i]);
    end

    // Output must not follow the input between edges
    apply(4'd5, 1'b0);
    check("load_5", bcd, 6'b00_0101);
    binary = 4'd14;
    #2;
    check("no_comb_path", bcd, 6'b00_0101);

    // Held input keeps the output steady
    apply(4'd12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(4'd12, 1'b0);
      check($sformatf("hold_%0d", i), bcd, 6'b01_0010);
    end

    // Back-to-back sweep with a reset dropped in the middle
    for (int v = 0; v < 16; v++) begin
      apply(4'(v), 1'b0);
      check($sformatf("sweep_%0d", v), bcd, table_bcd[v]);
      check($sformatf("sweep_b5_%0d", v), {5'b0, bcd[5]}, 6'd0);
      check($sformatf("sweep_le9_%0d", v), {5'b0, (bcd[3:0] <= 4'd9)}, 6'd1);
      if (v == 7) begin
        apply(4'b1101, 1'b1);
        check("mid_reset", bcd, 6'b00_0000);
        apply(4'b1101, 1'b0);
        check("mid_release", bcd, 6'b01_0011);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
